// File: rtl/sr_latch_write_arbiter.sv
// sr_latch_write_arbiter: round-robin write sequencer for a bank of gated SR latches.
// Each grant drives set/reset, then a single enable pulse, then a hold, all from registers.
module sr_latch_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_LATCH    = 8,
    parameter int IDX_W        = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                     clock,
    input  logic                     notreset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       reqOp,
    input  logic [NUM_REQ*IDX_W-1:0] reqIndex,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     ackError,
    output logic [NUM_LATCH-1:0]     latchEnable,
    output logic                     latchSet,
    output logic                     latchReset,
    output logic                     busy
);
    localparam int RW   = $clog2(NUM_REQ);
    localparam int MSP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAXC = (MSP > HOLD_CYCLES) ? MSP : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [RW-1:0]    r_last, r_id, w_id, w_win, w_cand;
    logic             r_op, w_op, w_found, w_grant, w_valid, w_done;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [IDX_W-1:0] w_ri [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_ri[g] = reqIndex[g*IDX_W +: IDX_W];
    end

    // Scan from lastGrant+1 upward, wrapping, and keep the first requester found.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_cand  = r_last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = RW'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // IDLE is entered with the counter at 1, giving one rest cycle before the next sample.
    assign w_grant = r_state == IDLE && r_cnt == '0 && w_found;

    always_comb begin
        w_state = r_state;
        w_cnt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
        case (r_state)
            IDLE:    if (w_grant) begin w_state = SETUP; w_cnt = CW'(SETUP_CYCLES - 1); end
            SETUP:   if (r_cnt == '0) begin w_state = PULSE; w_cnt = CW'(PULSE_CYCLES - 1); end
            PULSE:   if (r_cnt == '0) begin w_state = HOLD; w_cnt = CW'(HOLD_CYCLES - 1); end
            default: if (r_cnt == '0) begin w_state = IDLE; w_cnt = CW'(1); end
        endcase
    end

    assign w_id    = w_grant ? w_win : r_id;
    assign w_op    = w_grant ? reqOp[w_win] : r_op;
    assign w_idx   = w_grant ? w_ri[w_win] : r_idx;
    assign w_valid = int'(w_idx) < NUM_LATCH;
    assign w_done  = w_state == HOLD && w_cnt == '0;

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clock or negedge notreset) begin
        if (!notreset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= RW'(NUM_REQ - 1);
            r_id        <= '0;
            r_op        <= 1'b0;
            r_idx       <= '0;
            ack         <= '0;
            ackError    <= 1'b0;
            latchEnable <= '0;
            latchSet    <= 1'b0;
            latchReset  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_id        <= w_id;
            r_op        <= w_op;
            r_idx       <= w_idx;
            if (w_grant) r_last <= w_win;
            busy        <= w_state != IDLE;
            latchSet    <= w_state != IDLE && w_op;
            latchReset  <= w_state != IDLE && !w_op;
            latchEnable <= (w_state == PULSE && w_valid) ? NUM_LATCH'(1) << w_idx : '0;
            ack         <= w_done ? NUM_REQ'(1) << w_id : '0;
            ackError    <= w_done && !w_valid;
        end
    end
endmodule

// File: tb/tb_sr_latch_write_arbiter.sv
// tb_sr_latch_write_arbiter: two configurations checked every cycle against a phase-level model,
// with directed scenarios on the default configuration and random traffic on both.
module tb_sr_latch_write_arbiter;
    localparam int NR = 4;
    localparam int NL = 8;
    localparam int SS [2] = '{1, 3};
    localparam int PP [2] = '{2, 1};
    localparam int HH [2] = '{1, 2};

    logic clock = 1'b0;
    logic notreset = 1'b0;
    logic [NR-1:0]   req [2];
    logic [NR-1:0]   op [2];
    logic [NR*4-1:0] ri [2];
    logic [NR-1:0]   ack [2];
    logic [NL-1:0]   en [2];
    logic            err [2], lset [2], lrst [2], busy [2];

    int n_chk = 0, n_err = 0, cyc = 0;
    int k [2], last [2], mid [2], midx [2];
    logic mop [2], auto_on [2];
    logic [NL-1:0] pen [2];
    logic pset [2], prst [2];

    always #5 clock = ~clock;

    sr_latch_write_arbiter u_a (
        .clock(clock), .notreset(notreset), .req(req[0]), .reqOp(op[0]), .reqIndex(ri[0]),
        .ack(ack[0]), .ackError(err[0]), .latchEnable(en[0]), .latchSet(lset[0]),
        .latchReset(lrst[0]), .busy(busy[0])
    );

    sr_latch_write_arbiter #(.SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)) u_b (
        .clock(clock), .notreset(notreset), .req(req[1]), .reqOp(op[1]), .reqIndex(ri[1]),
        .ack(ack[1]), .ackError(err[1]), .latchEnable(en[1]), .latchSet(lset[1]),
        .latchReset(lrst[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic mreset(input int d);
        k[d] = 0; last[d] = NR - 1; pen[d] = '0; pset[d] = 1'b0; prst[d] = 1'b0;
    endtask

    // A write occupies phases 1..L; phase L+1 is the rest cycle; phase 0 accepts requests.
    task automatic advance(input int d);
        int L, c;
        L = SS[d] + PP[d] + HH[d];
        if (k[d] == 0) begin
            if (req[d] != '0) begin
                for (int i = 1; i <= NR; i++) begin
                    c = (last[d] + i) % NR;
                    if (req[d][c]) begin
                        mid[d] = c; last[d] = c; mop[d] = op[d][c]; midx[d] = int'(ri[d][c*4 +: 4]);
                        break;
                    end
                end
                k[d] = 1;
            end
        end else k[d] = (k[d] == L + 1) ? 0 : k[d] + 1;
    endtask

    task automatic checks(input int d);
        int L;
        logic act, chg;
        logic [NL-1:0] ee;
        L   = SS[d] + PP[d] + HH[d];
        act = k[d] >= 1 && k[d] <= L;
        ee  = (k[d] > SS[d] && k[d] <= SS[d] + PP[d] && midx[d] < NL) ? NL'(1) << midx[d] : '0;
        check(d ? "b_busy" : "a_busy", 32'(busy[d]), 32'(act));
        check(d ? "b_set" : "a_set", 32'(lset[d]), 32'(act && mop[d]));
        check(d ? "b_reset" : "a_reset", 32'(lrst[d]), 32'(act && !mop[d]));
        check(d ? "b_enable" : "a_enable", 32'(en[d]), 32'(ee));
        check(d ? "b_ack" : "a_ack", 32'(ack[d]), (k[d] == L) ? 32'(1) << mid[d] : 32'(0));
        check(d ? "b_ackerr" : "a_ackerr", 32'(err[d]), 32'(k[d] == L && midx[d] >= NL));
        check(d ? "b_onehot" : "a_onehot", 32'($onehot0(en[d])), 32'(1));
        check(d ? "b_excl" : "a_excl", 32'(lset[d] & lrst[d]), 32'(0));
        chg = (en[d] != '0 || pen[d] != '0) && ({lset[d], lrst[d]} != {pset[d], prst[d]});
        check(d ? "b_stable" : "a_stable", 32'(chg), 32'(0));
        pen[d] = en[d]; pset[d] = lset[d]; prst[d] = lrst[d];
    endtask

    task automatic stim(input int d);
        int L;
        L = SS[d] + PP[d] + HH[d];
        for (int i = 0; i < NR; i++) begin
            if (k[d] == L && mid[d] == i) req[d][i] = 1'b0;
            else if (auto_on[d]) begin
                if (!req[d][i] && $urandom_range(3) == 0) begin
                    req[d][i] = 1'b1;
                    op[d][i] = 1'($urandom_range(1));
                    ri[d][i*4 +: 4] = 4'($urandom_range(15));
                end else if (req[d][i] && $urandom_range(7) == 0) begin
                    op[d][i] = 1'($urandom_range(1));
                    ri[d][i*4 +: 4] = 4'($urandom_range(15));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        for (int d = 0; d < 2; d++) if (!notreset) mreset(d); else advance(d);
        @(negedge clock);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            checks(d);
            stim(d);
        end
    endtask

    initial begin
        int n, got, prev;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; op[d] = '0; ri[d] = '0; auto_on[d] = 1'b0; mid[d] = 0; midx[d] = 0; mop[d] = 1'b0;
            mreset(d);
        end
        auto_on[1] = 1'b1;
        repeat (3) step();
        notreset = 1'b1;
        repeat (20) step();

        req[0] = 4'hF; op[0] = 4'b1010; ri[0] = 16'h7531;
        got = 0; prev = 0;
        for (int i = 0; i < 60 && got < 4; i++) begin
            step();
            if (ack[0] != '0) begin
                check("grant_order", 32'(ack[0]), 32'(1) << got);
                if (got > 0) check("grant_gap", 32'(cyc - prev), 32'(6));
                prev = cyc;
                got++;
            end
        end
        check("grant_count", 32'(got), 32'(4));

        repeat (3) step();
        req[0][2] = 1'b1; op[0][2] = 1'b1; ri[0][11:8] = 4'd5;
        n = 0;
        while (ack[0] == '0 && n < 20) begin step(); n++; end
        check("set_latency", 32'(n), 32'(4));
        check("set_ack", 32'(ack[0]), 32'(4'b0100));
        step();
        check("set_idle", 32'(busy[0]), 32'(0));

        repeat (2) step();
        req[0][1] = 1'b1; op[0][1] = 1'b0; ri[0][7:4] = 4'd12;
        n = 0;
        while (ack[0] == '0 && n < 20) begin step(); n++; end
        check("oor_latency", 32'(n), 32'(4));
        check("oor_ack", 32'(ack[0]), 32'(4'b0010));
        check("oor_err", 32'(err[0]), 32'(1));

        repeat (2) step();
        req[0][1] = 1'b1; op[0][1] = 1'b1; ri[0][7:4] = 4'd3;
        n = 0;
        while (k[0] != SS[0] + 2 && n < 20) begin step(); n++; end
        check("pulse_reached", 32'(en[0]), 32'(8'h08));
        #1 notreset = 1'b0;
        #1;
        check("rst_enable", 32'(en[0]), 32'(0));
        check("rst_set", 32'(lset[0]), 32'(0));
        check("rst_busy", 32'(busy[0]), 32'(0));
        mreset(0); mreset(1);
        req[0][0] = 1'b1; op[0][0] = 1'b1; ri[0][3:0] = 4'd6;
        repeat (2) step();
        notreset = 1'b1;
        n = 0;
        while (ack[0] == '0 && n < 20) begin step(); n++; end
        check("rst_first_ack", 32'(ack[0]), 32'(4'b0001));

        auto_on[0] = 1'b1;
        repeat (1500) step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
